// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, default reset vector and word-size constants.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned BUF_ENTRY_W      = 2 * INSTR_W;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [INSTR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry FIFO of {pc, instruction} pairs between fetch and decode.
// The head is read straight from registers, so data is never combinational from memory.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = BUF_ENTRY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0][DATA_W-1:0] entry_data;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic                         do_push, do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'(DEPTH));
  assign head_data = empty ? '0 : entry_data[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (do_push && (wr_ptr_q == 1'(gi))) begin
          data_d = push_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign entry_data[gi] = data_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry buffer,
// with redirect handling that drops in-flight words and halts on misaligned targets.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        en,
  output logic [31:0] instruction_code,
  output logic [31:0] inst_pc,
  output logic        misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         misaligned_q, misaligned_d;

  logic                   buf_push, buf_pop, buf_full, buf_empty;
  logic [BUF_ENTRY_W-1:0] buf_head;
  logic                   xfer, keep_word;

  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (BUF_ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .push_data ({imem_addr, imem_rdata}),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign en                         = !buf_empty;
  assign {inst_pc, instruction_code} = buf_head;
  assign misaligned                 = misaligned_q;

  // Request generation: in IDLE nothing is outstanding, so occupancy alone gates a new fetch.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      IDLE: begin
        imem_req  = !rst && !buf_full && !misaligned_q;
        imem_addr = pc_q;
      end
      WAIT_ACK, DROP: begin
        imem_req  = !rst;
        imem_addr = req_addr_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
      end
    endcase
  end

  assign xfer      = imem_req && imem_ack;
  assign keep_word = xfer && (state_q != DROP) && !redirect_valid;
  assign buf_push  = keep_word;
  assign buf_pop   = en && dec_ready && !redirect_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    misaligned_d = misaligned_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      misaligned_d = is_misaligned(redirect_pc);
    end else if (keep_word) begin
      pc_d = pc_q + 32'd4;
    end

    unique case (state_q)
      IDLE: begin
        if (imem_req && !imem_ack) begin
          req_addr_d = pc_q;
          // A redirect in the request cycle still leaves this request on the bus.
          state_d    = redirect_valid ? DROP : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (imem_ack) begin
          state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a program-order reference (sequential pcs restarting at each redirect).
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        en;
  logic [31:0] instruction_code;
  logic [31:0] inst_pc;
  logic        misaligned;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_ready        (dec_ready),
    .en               (en),
    .instruction_code (instruction_code),
    .inst_pc          (inst_pc),
    .misaligned       (misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks a request once it has waited lat_now cycles (lat_mode < 0 = random).
  int   lat_mode = 0;
  int   rand_lat = 0;
  int   wait_cnt = 0;
  logic req_seen = 1'b0;

  always begin
    int lat_now;
    @(negedge clk);
    #1;
    if (rst) begin
      wait_cnt   = 0;
      req_seen   = 1'b0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end else begin
      if (imem_ack && req_seen) begin
        wait_cnt = 0;
        rand_lat = $urandom_range(0, 3);
      end else if (req_seen) begin
        wait_cnt++;
      end
      req_seen = imem_req;
      lat_now  = (lat_mode < 0) ? rand_lat : lat_mode;
      imem_ack = imem_req && (wait_cnt >= lat_now);
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    end
  end

  // Reference: consumed instructions follow program order from the last redirect target.
  logic [31:0] exp_pc     = RESET_PC;
  int          consumed   = 0;
  logic        prev_wait  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_tgt   = '0;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_pc     = RESET_PC;
      prev_wait  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) begin
        total_cnt++;
        if (en !== 1'b0 || misaligned !== (prev_tgt[1:0] != 2'b00))
          $display("FAIL redirect_flush: en=%b misaligned=%b required en=0 misaligned=%b",
                   en, misaligned, prev_tgt[1:0] != 2'b00);
        else pass_cnt++;
      end
      if (prev_wait) begin
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr)
          $display("FAIL req_stable: req=%b addr=%h required req=1 addr=%h",
                   imem_req, imem_addr, prev_addr);
        else pass_cnt++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (en && dec_ready) begin
        total_cnt++;
        if (inst_pc !== exp_pc || instruction_code !== mem_word(exp_pc))
          $display("FAIL order: pc=%h code=%h required pc=%h code=%h",
                   inst_pc, instruction_code, exp_pc, mem_word(exp_pc));
        else pass_cnt++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_wait  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      prev_redir = redirect_valid;
      prev_tgt   = redirect_pc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat_mode  = 5;
    dec_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total_cnt++;
      if (en !== 1'b0 || imem_req !== 1'b0 || instruction_code !== 32'h0 ||
          inst_pc !== 32'h0 || misaligned !== 1'b0)
        $display("FAIL reset_outputs: en=%b req=%b code=%h pc=%h mis=%b required all 0",
                 en, imem_req, instruction_code, inst_pc, misaligned);
      else pass_cnt++;
    end
    rst = 1'b0;
    #3;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL first_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    lat_mode  = 0;
    dec_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total_cnt++;
      if (en !== 1'b1 || inst_pc !== 32'(4 * (k - 1)))
        $display("FAIL zero_wait_stream: en=%b pc=%h required en=1 pc=%h", en, inst_pc, 32'(4 * (k - 1)));
      else pass_cnt++;
    end
    $display("test_zero_wait done");
  endtask

  task automatic test_stall();
    int en_cycles;
    @(negedge clk);
    dec_ready = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL stall_full: en=%b req=%b required en=1 req=0", en, imem_req);
    else pass_cnt++;
    lat_mode  = 1000;
    dec_ready = 1'b1;
    en_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (en) en_cycles++;
      @(negedge clk);
    end
    total_cnt++;
    if (en_cycles != 2)
      $display("FAIL stall_depth: buffered=%0d required 2", en_cycles);
    else pass_cnt++;
    lat_mode = 0;
    repeat (4) @(negedge clk);
    $display("test_stall done");
  endtask

  task automatic test_delayed_redirect();
    lat_mode  = 3;
    dec_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL wait_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL drop_hold: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL drop_refetch: en=%b req=%b addr=%h required en=0 req=1 addr=00000100",
               en, imem_req, imem_addr);
    else pass_cnt++;
    lat_mode = 0;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || inst_pc !== 32'h100 || instruction_code !== mem_word(32'h100))
      $display("FAIL drop_first: en=%b pc=%h code=%h required en=1 pc=00000100 code=%h",
               en, inst_pc, instruction_code, mem_word(32'h100));
    else pass_cnt++;
    repeat (3) @(negedge clk);
    $display("test_delayed_redirect done");
  endtask

  task automatic test_redirect_ack();
    logic [31:0] tgt;
    lat_mode  = 0;
    dec_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tgt      = $urandom;
      tgt[1:0] = 2'b00;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      @(negedge clk);
      redirect_valid = 1'b0;
      total_cnt++;
      if (en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== tgt)
        $display("FAIL redir_ack_req: en=%b req=%b addr=%h required en=0 req=1 addr=%h",
                 en, imem_req, imem_addr, tgt);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (en !== 1'b1 || inst_pc !== tgt)
        $display("FAIL redir_ack_first: en=%b pc=%h required en=1 pc=%h", en, inst_pc, tgt);
      else pass_cnt++;
      repeat (2) @(negedge clk);
    end
    $display("test_redirect_ack done");
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    total_cnt++;
    if (misaligned !== 1'b1 || imem_req !== 1'b0 || en !== 1'b0)
      $display("FAIL misaligned_set: mis=%b req=%b en=%b required mis=1 req=0 en=0",
               misaligned, imem_req, en);
    else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if (imem_req !== 1'b0 || misaligned !== 1'b1)
        $display("FAIL misaligned_halt: req=%b mis=%b required req=0 mis=1", imem_req, misaligned);
      else pass_cnt++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    total_cnt++;
    if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL misaligned_clear: mis=%b req=%b addr=%h required mis=0 req=1 addr=00000200",
               misaligned, imem_req, imem_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || inst_pc !== 32'h200)
      $display("FAIL misaligned_resume: en=%b pc=%h required en=1 pc=00000200", en, inst_pc);
    else pass_cnt++;
    $display("test_misaligned done");
  endtask

  task automatic test_reset_in_wait();
    lat_mode  = 5;
    dec_ready = 1'b1;
    do_reset();
    @(negedge clk);
    total_cnt++;
    if (imem_req !== 1'b1)
      $display("FAIL wait_before_rst: req=%b required 1", imem_req);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b0 || imem_req !== 1'b0 || instruction_code !== 32'h0 ||
        inst_pc !== 32'h0 || misaligned !== 1'b0)
      $display("FAIL rst_in_wait: en=%b req=%b code=%h pc=%h mis=%b required all 0",
               en, imem_req, instruction_code, inst_pc, misaligned);
    else pass_cnt++;
    lat_mode = 0;
    rst      = 1'b0;
    #3;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL rst_in_wait_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || inst_pc !== RESET_PC)
      $display("FAIL rst_in_wait_first: en=%b pc=%h required en=1 pc=%h", en, inst_pc, RESET_PC);
    else pass_cnt++;
    $display("test_reset_in_wait done");
  endtask

  task automatic test_random();
    int          start_consumed;
    logic [31:0] tgt;
    do_reset();
    lat_mode       = -1;
    start_consumed = consumed;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = $urandom_range(0, 32'h0000_FFFF);
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    dec_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (consumed - start_consumed < 50)
      $display("FAIL random_progress: consumed=%0d required >=50", consumed - start_consumed);
    else pass_cnt++;
    $display("test_random done: %0d instructions consumed", consumed - start_consumed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_delayed_redirect();
    test_redirect_ack();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the number of instruction buffer entries; the only supported value is 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have port imem_req output 1: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr output 32: word-aligned fetch address, valid while imem_req is high.
REQ-006 SHALL have port imem_ack input 1: memory completes the request this cycle.
REQ-007 SHALL have port imem_rdata input 32: instruction word, valid when imem_ack is high.
REQ-008 SHALL have port redirect_valid input 1: jump, branch or trap redirect.
REQ-009 SHALL have port redirect_pc input 32: target address, valid with redirect_valid.
REQ-010 SHALL have port dec_ready input 1: the decode stage consumes the head instruction this cycle.
REQ-011 SHALL have port en output 1: instruction_code is valid; drives the decoder enable.
REQ-012 SHALL have port instruction_code output 32: head instruction word.
REQ-013 SHALL have port inst_pc output 32: address of instruction_code.
REQ-014 SHALL have port misaligned output 1: the current redirect target has pc[1:0] != 0 and fetch is halted.

Function
REQ-015 SHALL use a FSM with states IDLE, WAIT_ACK and DROP.
REQ-016 IDLE: assert imem_req with imem_addr=pc when buffered entries + outstanding requests < BUF_DEPTH and misaligned=0; otherwise imem_req=0.
REQ-017 A transfer SHALL complete on the cycle imem_req && imem_ack, which may be the cycle the request is first raised; the module SHALL keep at most one request outstanding.
REQ-018 When imem_ack is not returned in the request cycle, the FSM SHALL enter WAIT_ACK and hold imem_req=1 with imem_addr stable until imem_ack.
REQ-019 On a completed transfer the module SHALL push {pc, imem_rdata} into the buffer and set pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
REQ-020 Latency: ack in cycle N SHALL give en=1 with that word in cycle N+1 when the buffer was empty; no combinational path from imem_rdata to instruction_code.
REQ-021 en SHALL equal buffer-non-empty; instruction_code and inst_pc SHALL show the head entry; the head SHALL pop on en && dec_ready.
REQ-022 Push and pop in the same cycle SHALL leave the occupancy count unchanged; a full buffer SHALL issue no request; an empty buffer SHALL drive en=0 and instruction_code=0.
REQ-023 redirect_valid SHALL flush the buffer (en=0 next cycle) and set pc <= redirect_pc; redirect has priority over push and pop in the same cycle.
REQ-024 Redirect while in WAIT_ACK without imem_ack: the FSM SHALL go to DROP, keep the old request stable, discard its data on ack, then return to IDLE and fetch redirect_pc.
REQ-025 Redirect coinciding with imem_ack: the acked word SHALL be discarded and the next request SHALL use redirect_pc.
REQ-026 Redirect in DROP SHALL update pc only and SHALL stay in DROP.
REQ-027 redirect_pc[1:0] != 0 SHALL set misaligned=1 and stop new requests (any outstanding request is still dropped) until the next aligned redirect clears it.

Reset
REQ-028 rst SHALL set pc=RESET_PC, FSM=IDLE, buffer empty, en=0, imem_req=0, instruction_code=0, inst_pc=0, misaligned=0.
REQ-029 An outstanding request at reset SHALL be abandoned; any imem_ack in the cycle after reset SHALL be ignored, with memory required to tolerate the dropped request.
REQ-030 The first request SHALL be raised in the cycle after rst deasserts.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, RESET_PC default, NOP constant 32'h0000_0013 and the instruction width constant.
REQ-032 The 2-entry buffer SHALL be a sub-module fetch_buffer (push, pop, flush, full, empty, 64-bit data).

Verification
REQ-033 Zero-wait memory (ack same cycle), dec_ready=1 -> one instruction per cycle, inst_pc 0,4,8,... and en=1 from cycle 2 after reset.
REQ-034 dec_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_req=0, no word lost, order preserved on release.
REQ-035 Ack delayed 3 cycles, redirect to 32'h100 in the 2nd wait cycle -> stale word discarded, next imem_addr=32'h100, en shows pc 0x100 first.
REQ-036 Redirect concurrent with ack -> acked word never appears on en; next inst_pc=redirect_pc.
REQ-037 Redirect to 32'h102 -> misaligned=1, imem_req=0; redirect to 32'h200 -> misaligned=0 and fetch resumes at 0x200.
REQ-038 rst asserted in WAIT_ACK -> all outputs at reset values next cycle; first imem_addr=RESET_PC after release.
